gray_sobel3x3: RTL and testbench
================================

# gray_sobel3x3

Streaming 3x3 neighbourhood filter that sits directly downstream of the Bayer-to-gray converter. It consumes the decimated 12-bit gray pixel stream and its data-valid strobe. It produces one 12-bit edge-magnitude (or pass-through) pixel per accepted input pixel, for the VGA/SDRAM write path. Two line buffers and a 3x3 window register hold the neighbourhood; a two-stage arithmetic pipeline computes a Sobel gradient.

## Interface
- LINE_WIDTH, 640: gray pixels per line (valid strobes per row); minimum 4.
- DATA_W, 12: pixel width; all arithmetic below is stated for 12.
- iCLK  in  1  single clock; all state on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iGRAY  in  12  gray pixel, raster order.
- iDVAL  in  1  iGRAY valid this cycle; gaps of any length allowed.
- iFVAL  in  1  frame active; low clears position counters.
- iMODE  in  2  00 pass-through, 01 |Gx|, 10 |Gy|, 11 |Gx|+|Gy|.
- oGRAY  out  12  filtered pixel.
- oDVAL  out  1  oGRAY valid.

## Operation
- Accepted sample: iDVAL=1 and iFVAL=1. iDVAL while iFVAL=0 is ignored: no shift, no output.
- Column counter col (0..LINE_WIDTH-1):
  - increments per accepted sample and wraps to 0 after LINE_WIDTH-1;
  - each wrap increments the row counter row, which saturates at 2047;
  - both counters clear while iFVAL=0.
- Line buffers: two cascaded shift FIFOs of depth LINE_WIDTH, clock-enabled by accepted sample. Taps give the pixel 1 row and 2 rows above.
- Window: 3x3 register array w[r][c], shifted left on each accepted sample. The new column is {tap2, tap1, iGRAY}. Window centre is the pixel at (row-1, col-1).
- Mode is latched into mode_q on the iFVAL rising edge and held for the whole frame. Mid-frame iMODE changes have no effect.
- Gradients:
  - Gx = (w02+2w12+w22) − (w00+2w10+w20).
  - Gy = (w20+2w21+w22) − (w00+2w01+w02).
  - Signed 15-bit intermediates; range ±16380.
- Output value:
  - abs of the selected gradient, or sum of both abs values (unsigned 15-bit);
  - saturate to 4095;
  - mode 00 outputs the centre pixel w11 unchanged.
- Border: when the centre pixel has row-1<1 or col-1<1, the sample's output is 0. This covers the first two accepted rows and the first two accepted columns. The last row/column of the frame never becomes a centre and is not emitted. One output is produced per accepted input, so the pixel count is preserved.
- Reset:
  - asynchronously clears counters, window, pipeline registers, mode_q (to 00), oGRAY=0 and oDVAL=0;
  - line buffer contents are not cleared; the border masking hides them.

## Timing
- Latency 2: an accepted sample at edge N gives oDVAL=1 with its result valid after edge N+2.
- Stage 1 (edge N+1): window shift done, Gx/Gy registered, border flag registered.
- Stage 2 (edge N+2): abs, add, saturate and mask registered.
- oDVAL is a 2-cycle delayed copy of "accepted". Gaps in iDVAL reproduce as identical gaps in oDVAL.
- The pipeline is not stalled by gaps. A sample in flight when iFVAL falls still emits.
- Reset mid-frame: oDVAL low from assertion until the second accepted sample after release. Row/col restart at 0.

## Structure
- Shared package gray_pkg holds:
  - PIX_W=12, PIX_MAX=12'hFFF;
  - the mode enum (MODE_PASS, MODE_GX, MODE_GY, MODE_SUM);
  - the signed gradient type (15-bit).
- Sub-module gray_line_buffer: parameterised depth/width shift FIFO with clken and one output tap. Instantiated twice, cascaded.

## Test plan
- LINE_WIDTH=8, constant 1000, mode 01 → 64 outputs, all 0. oDVAL count 64, latency 2.
- Mode 00, pixel value = 10·row+col → output at accepted index k (row r, col c, r≥2, c≥2) equals 10(r−1)+(c−1). Borders are 0.
- Columns 0–3 = 0, 4–7 = 4095, mode 01 → rows≥2 at col 4 and 5 (centres 3, 4) give 4095 (16380 saturated). Other interior outputs 0. Mode 10 gives all 0.
- Ramp pixel = 10·col → mode 01 interior = 80. Ramp 4095−10·col → 80 (abs). Mode 11 on pixel = 10·col+10·row → 160.
- iDVAL gaps of 1–5 cycles between random pixels → outputs identical to the gap-free run, and oDVAL gaps mirror the input gaps.
- iRST low for 1 cycle mid-row 3 → oDVAL=0 and oGRAY=0 immediately. After release, mode_q=00 and the first two rows/columns output 0. iMODE changes mid-frame → no effect until the next iFVAL rise.

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, constants and column-sum helpers for the gray Sobel filter
package gray_pkg;

    localparam int PIX_W  = 12;
    localparam int GRAD_W = 15;
    localparam logic [PIX_W-1:0] PIX_MAX = 12'hFFF;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [GRAD_W-1:0]        mag_t;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_GX   = 2'b01,
        MODE_GY   = 2'b10,
        MODE_SUM  = 2'b11
    } mode_t;

    // Weighted 1-2-1 sum of three pixels; at most 4*4095, so it fits a positive grad_t.
    function automatic grad_t col_sum(input pix_t a, input pix_t b, input pix_t c);
        return grad_t'({3'b000, a}) + grad_t'({2'b00, b, 1'b0}) + grad_t'({3'b000, c});
    endfunction

    function automatic mag_t grad_abs(input grad_t g);
        return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// rtl/gray_line_buffer.sv - clock-enabled shift FIFO whose tap is the sample DEPTH enables ago
module gray_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_clken,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_tap
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: stale contents only ever reach border positions, which are masked downstream.
    always_ff @(posedge i_clk) begin
        if (i_clken) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_tap = r_mem[DEPTH-1];

endmodule

// File: rtl/gray_sobel3x3.sv
// rtl/gray_sobel3x3.sv - streaming 3x3 Sobel edge-magnitude / pass-through filter, latency 2
module gray_sobel3x3
    import gray_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int DATA_W     = PIX_W
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iGRAY,
    input  logic              iDVAL,
    input  logic              iFVAL,
    input  logic [1:0]        iMODE,
    output logic [DATA_W-1:0] oGRAY,
    output logic              oDVAL
);

    localparam int COL_W = $clog2(LINE_WIDTH);
    localparam int ROW_W = 11;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = {ROW_W{1'b1}};

    logic             w_acc;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_fval_d;
    mode_t            r_mode;

    pix_t             w_pix;
    pix_t             w_tap1;
    pix_t             w_tap2;
    pix_t             r_win [3][2];

    grad_t            w_gx;
    grad_t            w_gy;
    logic             w_border;

    grad_t            r_gx;
    grad_t            r_gy;
    pix_t             r_ctr;
    logic             r_border;
    logic             r_v1;

    mag_t             w_ax;
    mag_t             w_ay;
    mag_t             w_mag;
    pix_t             w_res;
    pix_t             r_out;
    logic             r_odval;

    assign w_acc = iDVAL & iFVAL;
    assign w_pix = pix_t'(iGRAY);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_col <= '0;
            r_row <= '0;
        end else if (!iFVAL) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row != ROW_MAX) begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Reset leaves the "previous iFVAL" high so a reset inside a frame keeps mode_q at pass-through
    // until the next genuine frame start.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_fval_d <= 1'b1;
            r_mode   <= MODE_PASS;
        end else begin
            r_fval_d <= iFVAL;
            if (iFVAL && !r_fval_d) begin
                r_mode <= mode_t'(iMODE);
            end
        end
    end

    gray_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .i_clk   (iCLK),
        .i_clken (w_acc),
        .i_data  (w_pix),
        .o_tap   (w_tap1)
    );

    gray_line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(PIX_W)) u_lb2 (
        .i_clk   (iCLK),
        .i_clken (w_acc),
        .i_data  (w_tap1),
        .o_tap   (w_tap2)
    );

    // The right-hand window column is the live {tap2, tap1, iGRAY}; only the two older columns
    // are held in registers, so the gradient of the shifted window is available in the same cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= '0;
                r_win[r][1] <= '0;
            end
        end else if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
            end
            r_win[0][1] <= w_tap2;
            r_win[1][1] <= w_tap1;
            r_win[2][1] <= w_pix;
        end
    end

    assign w_gx = col_sum(w_tap2, w_tap1, w_pix)
                - col_sum(r_win[0][0], r_win[1][0], r_win[2][0]);
    assign w_gy = col_sum(r_win[2][0], r_win[2][1], w_pix)
                - col_sum(r_win[0][0], r_win[0][1], w_tap2);
    assign w_border = (r_row < ROW_W'(2)) || (r_col < COL_W'(2));

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_gx     <= '0;
            r_gy     <= '0;
            r_ctr    <= '0;
            r_border <= 1'b1;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_gx     <= w_gx;
                r_gy     <= w_gy;
                r_ctr    <= r_win[1][1];
                r_border <= w_border;
            end
        end
    end

    assign w_ax = grad_abs(r_gx);
    assign w_ay = grad_abs(r_gy);

    always_comb begin
        w_mag = '0;
        case (r_mode)
            MODE_PASS: w_mag = mag_t'(r_ctr);
            MODE_GX:   w_mag = w_ax;
            MODE_GY:   w_mag = w_ay;
            MODE_SUM:  w_mag = w_ax + w_ay;
            default:   w_mag = '0;
        endcase
    end

    always_comb begin
        w_res = '0;
        if (!r_border) begin
            w_res = (w_mag > mag_t'(PIX_MAX)) ? PIX_MAX : w_mag[PIX_W-1:0];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_out   <= '0;
            r_odval <= 1'b0;
        end else begin
            r_odval <= r_v1;
            if (r_v1) begin
                r_out <= w_res;
            end
        end
    end

    assign oGRAY = DATA_W'(r_out);
    assign oDVAL = r_odval;

endmodule

// File: tb/tb_gray_sobel3x3.sv
// tb/tb_gray_sobel3x3.sv - randomized self-checking bench for gray_sobel3x3 against a frame-level model
module tb_gray_sobel3x3;

    localparam int W = 8;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [11:0] iGRAY = '0;
    logic        iDVAL = 1'b0;
    logic        iFVAL = 1'b0;
    logic [1:0]  iMODE = '0;
    logic [11:0] oGRAY;
    logic        oDVAL;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int acc_q[$];
    int out_cyc_q[$];
    int out_val_q[$];
    int saved_q[$];
    logic [11:0] pix [0:127];

    gray_sobel3x3 #(.LINE_WIDTH(W), .DATA_W(12)) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iGRAY (iGRAY),
        .iDVAL (iDVAL),
        .iFVAL (iFVAL),
        .iMODE (iMODE),
        .oGRAY (oGRAY),
        .oDVAL (oDVAL)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(negedge iCLK) begin
        if (iRST && iDVAL && iFVAL) acc_q.push_back(cyc);
        if (oDVAL) begin
            out_cyc_q.push_back(cyc);
            out_val_q.push_back(int'(oGRAY));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output for accepted sample k of a frame: centre (r-1,c-1), window top-left (r-2,c-2).
    function automatic int model(input int k, input int mode);
        int r, c, gx, gy, ax, ay, v;
        int p [3][3];
        r = k / W;
        c = k % W;
        if (r < 2 || c < 2) return 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                p[dr][dc] = int'(pix[(r - 2 + dr) * W + (c - 2 + dc)]);
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mode)
            0:       v = p[1][1];
            1:       v = ax;
            2:       v = ay;
            default: v = ax + ay;
        endcase
        return (v > 4095) ? 4095 : v;
    endfunction

    task automatic clear_q();
        acc_q.delete();
        out_cyc_q.delete();
        out_val_q.delete();
    endtask

    task automatic drive_samples(input int n, input int gapmax);
        for (int k = 0; k < n; k++) begin
            if (k > 0 && gapmax > 0) begin
                repeat ($urandom_range(1, gapmax)) begin
                    iDVAL = 1'b0;
                    iGRAY = 12'($urandom);
                    iMODE = 2'($urandom);
                    @(posedge iCLK); #1;
                end
            end
            iDVAL = 1'b1;
            iGRAY = pix[k];
            if (k > 0) iMODE = 2'($urandom);
            @(posedge iCLK); #1;
        end
        iDVAL = 1'b0;
    endtask

    task automatic frame_start(input int mode);
        iFVAL = 1'b0;
        iDVAL = 1'b1;
        iGRAY = 12'($urandom);
        iMODE = 2'(mode);
        @(posedge iCLK); #1;
        iDVAL = 1'b0;
        repeat (2) begin @(posedge iCLK); #1; end
        clear_q();
        iMODE = 2'(mode);
        iFVAL = 1'b1;
    endtask

    task automatic frame_end();
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        repeat (4) begin @(posedge iCLK); #1; end
    endtask

    task automatic check_frame(input string tag, input int n, input int mode);
        check({tag, "_nacc"}, acc_q.size(), n);
        check({tag, "_nout"}, out_val_q.size(), n);
        for (int k = 0; k < n && k < out_val_q.size(); k++) begin
            check($sformatf("%s_v%0d", tag, k), out_val_q[k], model(k, mode));
            if (k < acc_q.size())
                check($sformatf("%s_lat%0d", tag, k), out_cyc_q[k] - acc_q[k], 2);
        end
    endtask

    task automatic run_frame(input string tag, input int n, input int mode, input int gapmax);
        frame_start(mode);
        drive_samples(n, gapmax);
        frame_end();
        check_frame(tag, n, mode);
    endtask

    initial begin
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_odval", int'(oDVAL), 0);
        check("rst_ogray", int'(oGRAY), 0);
        iRST = 1'b1;
        repeat (2) begin @(posedge iCLK); #1; end

        for (int i = 0; i < 64; i++) pix[i] = 12'd1000;
        run_frame("const", 64, 1, 0);

        for (int i = 0; i < 64; i++) pix[i] = 12'(10 * (i / W) + (i % W));
        run_frame("pass", 64, 0, 0);

        for (int i = 0; i < 64; i++) pix[i] = ((i % W) < 4) ? 12'd0 : 12'd4095;
        run_frame("step_gx", 64, 1, 0);
        run_frame("step_gy", 64, 2, 0);

        for (int i = 0; i < 64; i++) pix[i] = 12'(10 * (i % W));
        run_frame("ramp_up", 64, 1, 0);
        for (int i = 0; i < 64; i++) pix[i] = 12'(4095 - 10 * (i % W));
        run_frame("ramp_dn", 64, 1, 0);
        for (int i = 0; i < 64; i++) pix[i] = 12'(10 * (i % W) + 10 * (i / W));
        run_frame("ramp_sum", 64, 3, 0);

        for (int i = 0; i < 80; i++) pix[i] = 12'($urandom);
        run_frame("rnd_nogap", 80, 3, 0);
        saved_q = out_val_q;
        run_frame("rnd_gap", 80, 3, 5);
        for (int k = 0; k < 80 && k < out_val_q.size() && k < saved_q.size(); k++)
            check($sformatf("gap_vs_nogap%0d", k), out_val_q[k], saved_q[k]);

        for (int i = 0; i < 64; i++) pix[i] = 12'($urandom);
        frame_start(1);
        drive_samples(3 * W + 3, 0);
        #2 iRST = 1'b0;
        #1;
        check("midrst_odval", int'(oDVAL), 0);
        check("midrst_ogray", int'(oGRAY), 0);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        clear_q();
        drive_samples(48, 2);
        frame_end();
        check_frame("after_rst", 48, 0);

        run_frame("relatch", 64, 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
